// File: rtl/agu_burst.sv
// Registered address generator: owns the PC, forms a base address from
// arg/PC/carry-in and streams a strided burst of addresses over valid/ready.
module agu_burst #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              pc_inc,
  output logic [ADDR_W-1:0] pc,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_arg,
  input  logic              req_e_arg,
  input  logic              req_e_pc,
  input  logic              req_inc,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [STEP_W-1:0] req_step,
  input  logic              req_dec,
  output logic              adr_valid,
  input  logic              adr_ready,
  output logic [ADDR_W-1:0] adr,
  output logic              adr_last,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   count;
  logic [ADDR_W-1:0]  stride;
  logic               dir;
  logic [ADDR_W-1:0]  base_c;
  logic               accept_c;
  logic               beat_done_c;

  // Ready only in IDLE; independent of req_valid so producers can hold requests.
  assign req_ready   = (state == IDLE) && !rst;
  assign accept_c    = req_valid && req_ready;
  assign beat_done_c = adr_valid && adr_ready;
  assign busy        = adr_valid;

  // Base address uses the PC as it stands before any same-cycle PC update.
  always_comb begin
    base_c = '0;
    if (req_e_arg) base_c = base_c + req_arg;
    if (req_e_pc)  base_c = base_c + pc;
    base_c = base_c + ADDR_W'(req_inc);
  end

  // Program counter: load beats increment; independent of burst state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (pc_load) begin
      pc <= pc_load_val;
    end else if (pc_inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

  // Burst FSM with registered address stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      adr_valid <= 1'b0;
      adr       <= '0;
      adr_last  <= 1'b0;
      count     <= '0;
      stride    <= '0;
      dir       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            adr       <= base_c;
            count     <= req_len;
            adr_last  <= (req_len == '0);
            adr_valid <= 1'b1;
            stride    <= ADDR_W'(req_step);
            dir       <= req_dec;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (beat_done_c) begin
            if (count != '0) begin
              adr      <= dir ? (adr - stride) : (adr + stride);
              count    <= count - LEN_W'(1);
              adr_last <= (count == LEN_W'(1));
            end else begin
              adr_valid <= 1'b0;
              adr_last  <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          adr_valid <= 1'b0;
          adr_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
